// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
// Drives the two-input basic-gate block through all four (a,b) vectors,
// samples its seven outputs back and compares them against the ideal gate
// functions. Per-gate mismatches accumulate into a sticky fail mask and a
// saturating error-bit count. Pass/fail is reported with a one-cycle done
// pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a sweep (honoured only when idle)
//   gate_in    gate outputs: 0 and, 1 or, 2 not(a), 3 nand, 4 nor, 5 xor, 6 xnor
//   a, b       registered stimulus, a = vector_idx[1], b = vector_idx[0]
//   busy       high while settling/checking
//   done       one-cycle pulse at end of a completed sweep
//   pass       fail_mask == 0 at end of sweep, held until next start
//   fail_mask  sticky per-gate mismatch flags
//   err_count  saturating count of mismatched output bits
//   vector_idx current vector index
module gate_sweep_checker #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [6:0]       gate_in,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [6:0]       fail_mask,
   output logic [CNT_W-1:0] err_count,
   output logic [1:0]       vector_idx
);

   localparam int SCW  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
   // Headroom for one CHECK's worth of mismatches (at most 7) above the counter.
   localparam int SUMW = CNT_W + 3;
   localparam logic [SCW-1:0] SETTLE_LD = SCW'(SETTLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   state_t           state_q;
   logic [SCW-1:0]   cnt_q;
   logic             a_q, b_q, busy_q, done_q, pass_q;
   logic [6:0]       fail_mask_q, fail_mask_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [1:0]       idx_q, idx_d;

   logic [6:0]       expected, mism;
   logic [2:0]       popcnt;
   logic [SUMW-1:0]  sum;

   always_comb begin
      expected = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q),
                  ~a_q, a_q | b_q, a_q & b_q};
      mism     = gate_in ^ expected;
      popcnt   = '0;
      for (int i = 0; i < 7; i++) popcnt = popcnt + 3'(mism[i]);
      sum         = SUMW'(err_count_q) + SUMW'(popcnt);
      // Any carry into the headroom bits means the counter would wrap: pin it.
      err_count_d = (|sum[SUMW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
      fail_mask_d = fail_mask_q | mism;
      idx_d       = idx_q + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= '0;
         err_count_q <= '0;
         idx_q       <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= SETTLE;
                  busy_q      <= 1'b1;
                  fail_mask_q <= '0;
                  err_count_q <= '0;
                  pass_q      <= 1'b0;
                  idx_q       <= '0;
                  a_q         <= 1'b0;
                  b_q         <= 1'b0;
                  cnt_q       <= SETTLE_LD;
               end
            end
            SETTLE: begin
               // Counter holds the remaining settle cycles including this one.
               if (cnt_q == SCW'(1)) state_q <= CHECK;
               else                  cnt_q   <= cnt_q - SCW'(1);
            end
            CHECK: begin
               fail_mask_q <= fail_mask_d;
               err_count_q <= err_count_d;
               if (idx_q == 2'd3) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (fail_mask_d == '0);
               end else begin
                  state_q <= SETTLE;
                  idx_q   <= idx_d;
                  a_q     <= idx_d[1];
                  b_q     <= idx_d[0];
                  cnt_q   <= SETTLE_LD;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a          = a_q;
   assign b          = b_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail_mask  = fail_mask_q;
   assign err_count  = err_count_q;
   assign vector_idx = idx_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker. Instance 0: SETTLE_CYCLES=1, CNT_W=5, gate
// plant combinational. Instance 1: SETTLE_CYCLES=3, CNT_W=3, gate plant
// delayed by two registers. The plant is a truth-table model with injectable
// stuck-at/invert faults. Expected sweep results are queued at start issue; a
// monitor tracks sweep phase from rst/start and checks outputs every cycle,
// popping the queue on each done.
module tb_gate_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] fm;
      int         err;
      logic       pass;
   } exp_t;

   logic       rst;
   logic [1:0] st;
   logic [1:0] a_w, b_w, busy_w, done_w, pass_w;
   logic [6:0] fm_w [2];
   logic [1:0] idx_w [2];
   logic [4:0] err0;
   logic [2:0] err1;
   logic [6:0] gin0, gm1, p1, p2;
   logic [6:0] s0 [2], s1 [2], inv [2];
   bit         finished = 1'b0;

   exp_t exp_q0 [$];
   exp_t exp_q1 [$];

   int n_cmp = 0;
   int n_err = 0;

   function automatic int sset(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Truth tables indexed by {a,b}; bit order matches gate_in.
   function automatic logic [6:0] gate_vec(input logic a, input logic b,
                                           input logic [6:0] z, input logic [6:0] o,
                                           input logic [6:0] n);
      logic [3:0] tt [7];
      logic [6:0] r;
      logic       ideal;
      tt = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
      r  = '0;
      for (int g = 0; g < 7; g++) begin
         ideal = tt[g][{a, b}];
         r[g]  = z[g] ? 1'b0 : o[g] ? 1'b1 : n[g] ? ~ideal : ideal;
      end
      return r;
   endfunction

   assign gin0 = gate_vec(a_w[0], b_w[0], s0[0], s1[0], inv[0]);
   assign gm1  = gate_vec(a_w[1], b_w[1], s0[1], s1[1], inv[1]);
   always @(posedge clk) begin
      p1 <= gm1;
      p2 <= p1;
   end

   gate_sweep_checker #(.SETTLE_CYCLES(1), .CNT_W(5)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .gate_in(gin0),
      .a(a_w[0]), .b(b_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .fail_mask(fm_w[0]), .err_count(err0), .vector_idx(idx_w[0]));

   gate_sweep_checker #(.SETTLE_CYCLES(3), .CNT_W(3)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .gate_in(p2),
      .a(a_w[1]), .b(b_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .fail_mask(fm_w[1]), .err_count(err1), .vector_idx(idx_w[1]));

   // Expected sweep outcome: compare the faulty plant to the clean truth table.
   function automatic exp_t predict(input int k);
      exp_t       e;
      logic [6:0] m;
      int         mx;
      e.fm  = '0;
      e.err = 0;
      for (int v = 0; v < 4; v++) begin
         m = gate_vec(v[1], v[0], s0[k], s1[k], inv[k]) ^ gate_vec(v[1], v[0], '0, '0, '0);
         e.fm = e.fm | m;
         for (int g = 0; g < 7; g++) e.err += int'(m[g]);
      end
      mx = (k == 0) ? 31 : 7;
      if (e.err > mx) e.err = mx;
      e.pass = (e.fm == 7'd0);
      return e;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int k, input exp_t e);
      if (k == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   // mode 0 clean, 1 xor stuck-at-0, 2 all inverted, 3 random faults
   task automatic set_fault(input int k, input int mode);
      int r;
      s0[k] = '0; s1[k] = '0; inv[k] = '0;
      case (mode)
         1: s0[k][5] = 1'b1;
         2: inv[k] = 7'h7F;
         3: if ($urandom_range(0, 3) != 0) begin
               for (int g = 0; g < 7; g++) begin
                  r = $urandom_range(0, 5);
                  if (r == 0) s0[k][g] = 1'b1;
                  else if (r == 1) s1[k][g] = 1'b1;
                  else if (r == 2) inv[k][g] = 1'b1;
               end
            end
         default: ;
      endcase
   endtask

   // ign 1: extra start while vector 1 settles; ign 2: extra start in DONE.
   // Returns in the first idle cycle after done (earliest legal restart).
   task automatic run_sweep(input int k, input int mode, input int ign);
      int s, d;
      s = sset(k);
      d = 4 * (s + 1) + 1;
      set_fault(k, mode);
      push(k, predict(k));
      st[k] = 1'b1;
      cyc();
      st[k] = 1'b0;
      for (int c = 1; c <= d; c++) begin
         st[k] = (ign == 1 && c == s + 2) || (ign == 2 && c == d);
         cyc();
      end
      st[k] = 1'b0;
   endtask

   task automatic held(input int k);
      int   d;
      exp_t e;
      d = 4 * (sset(k) + 1) + 1;
      set_fault(k, 3);
      e = predict(k);
      push(k, e);
      push(k, e);
      st[k] = 1'b1;
      repeat (d + 2) cyc();
      st[k] = 1'b0;
      repeat (d) cyc();
   endtask

   task automatic abort(input int k);
      int s, d;
      s = sset(k);
      d = 4 * (s + 1) + 1;
      set_fault(k, 3);
      push(k, predict(k));
      st[k] = 1'b1;
      cyc();
      st[k] = 1'b0;
      repeat (2 * (s + 1)) cyc();
      rst = 1'b1;
      if (k == 0) void'(exp_q0.pop_back());
      else        void'(exp_q1.pop_back());
      cyc();
      rst = 1'b0;
      repeat (d + 2) cyc();
   endtask

   task automatic chk(input string nm, input int k, input int act, input int ex);
      n_cmp++;
      if (act != ex) begin
         n_err++;
         $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, k, act, ex, $time);
      end
   endtask

   // Stimulus
   initial begin
      rst = 1'b1;
      st  = 2'b11;
      for (int k = 0; k < 2; k++) set_fault(k, 3);
      repeat (2) cyc();
      rst = 1'b0;
      st  = 2'b00;
      cyc();
      for (int k = 0; k < 2; k++) begin
         run_sweep(k, 0, 0);
         run_sweep(k, 1, 1);
         run_sweep(k, 2, 2);
         for (int i = 0; i < 6; i++) run_sweep(k, 3, $urandom_range(0, 2));
         held(k);
         abort(k);
         run_sweep(k, 2, 0);
         run_sweep(k, 0, 0);
      end
      repeat (3) cyc();
      finished = 1'b1;
      repeat (10) cyc();
      $display("FAIL monitor did not finish the run");
      $fatal(1);
   end

   // Monitor: phase is cycles since the accepted start edge (-1 = idle).
   initial begin
      int   ph [2];
      bit   vld [2];
      int   idle_idx [2];
      exp_t last [2];
      exp_t e;
      int   s, d, xi, errv;
      for (int k = 0; k < 2; k++) begin
         ph[k] = -1; vld[k] = 1'b0; idle_idx[k] = 0;
         last[k] = '{7'd0, 0, 1'b0};
      end
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            d = 4 * (sset(k) + 1) + 1;
            if (rst) begin
               vld[k] = 1'b1; ph[k] = -1; idle_idx[k] = 0;
               last[k] = '{7'd0, 0, 1'b0};
            end else if (vld[k]) begin
               if (ph[k] == -1) begin
                  if (st[k]) ph[k] = 1;
               end else if (ph[k] == d) begin
                  ph[k] = -1;
                  idle_idx[k] = 3;
               end else ph[k]++;
            end
         end
         @(negedge clk);
         if (finished) begin
            chk("queue_left", 0, exp_q0.size(), 0);
            chk("queue_left", 1, exp_q1.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
         end
         for (int k = 0; k < 2; k++) begin
            if (!vld[k]) continue;
            s    = sset(k);
            d    = 4 * (s + 1) + 1;
            errv = (k == 0) ? int'(err0) : int'(err1);
            if (ph[k] == -1) begin
               xi = idle_idx[k];
               chk("idle_busy", k, int'(busy_w[k]), 0);
               chk("idle_done", k, int'(done_w[k]), 0);
               chk("idle_idx", k, int'(idx_w[k]), xi);
               chk("idle_ab", k, int'({a_w[k], b_w[k]}), xi);
               chk("hold_fail_mask", k, int'(fm_w[k]), int'(last[k].fm));
               chk("hold_err_count", k, errv, last[k].err);
               chk("hold_pass", k, int'(pass_w[k]), int'(last[k].pass));
            end else if (ph[k] < d) begin
               xi = (ph[k] - 1) / (s + 1);
               chk("sweep_busy", k, int'(busy_w[k]), 1);
               chk("sweep_done", k, int'(done_w[k]), 0);
               chk("sweep_idx", k, int'(idx_w[k]), xi);
               chk("sweep_ab", k, int'({a_w[k], b_w[k]}), xi);
               if (ph[k] == 1) begin
                  chk("start_clear_fm", k, int'(fm_w[k]), 0);
                  chk("start_clear_err", k, errv, 0);
                  chk("start_clear_pass", k, int'(pass_w[k]), 0);
               end
            end else begin
               chk("end_busy", k, int'(busy_w[k]), 0);
               chk("end_done", k, int'(done_w[k]), 1);
               chk("end_idx", k, int'(idx_w[k]), 3);
               if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                  chk("scoreboard_empty_at_done", k, 0, 1);
               end else begin
                  e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  chk("result_fail_mask", k, int'(fm_w[k]), int'(e.fm));
                  chk("result_err_count", k, errv, e.err);
                  chk("result_pass", k, int'(pass_w[k]), int'(e.pass));
                  last[k] = e;
               end
            end
         end
      end
   end

endmodule
